// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line/clock rates and
// the bit-period derivation used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RECV  = 3'd2,
    STOP  = 3'd3
  } uart_state_t;

  localparam int DEFAULT_BIT_RATE = 115200;
  localparam int DEFAULT_CLK_HZ   = 50_000_000;

  // Integer nanosecond periods, so the result matches the transmitter exactly.
  function automatic int cycles_per_bit(input int bit_rate, input int clk_hz);
    return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
  endfunction

  function automatic int count_reg_len(input int cpb);
    return 1 + $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs, with a
// selectable reset value so idle-high lines do not glitch out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised pin, mid-bit sampling with start-glitch
// rejection, framing-error and break detection, one-cycle result pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = DEFAULT_BIT_RATE,
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int COUNT_REG_LEN  = count_reg_len(CYCLES_PER_BIT);

  localparam logic [COUNT_REG_LEN-1:0] CNT_FULL = COUNT_REG_LEN'(CYCLES_PER_BIT);
  localparam logic [COUNT_REG_LEN-1:0] CNT_HALF = COUNT_REG_LEN'(HALF_BIT);
  localparam logic [COUNT_REG_LEN-1:0] CNT_ONE  = COUNT_REG_LEN'(1);
  localparam logic [3:0]               LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]               LAST_STOP = 4'(STOP_BITS - 1);

  logic                     rxd_s;
  logic                     rxd_q;
  uart_state_t              state;
  logic [COUNT_REG_LEN-1:0] cycle_cnt;
  logic [3:0]               bit_cnt;
  logic [PAYLOAD_BITS-1:0]  shreg;
  logic                     stop_bad;
  logic                     sample;
  logic                     bad_frame;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rxd_q <= 1'b1;
    else         rxd_q <= rxd_s;
  end

  assign sample       = (cycle_cnt == CNT_FULL);
  assign bad_frame    = stop_bad | ~rxd_s;
  assign uart_rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      cycle_cnt         <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      stop_bad          <= 1'b0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
    end else begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      case (state)
        IDLE: begin
          // A falling edge is required, so a line stuck low never re-triggers.
          if (uart_rx_en && rxd_q && !rxd_s) begin
            state     <= START;
            cycle_cnt <= '0;
          end
        end
        START: begin
          if (cycle_cnt == CNT_HALF) begin
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            state     <= rxd_s ? IDLE : RECV;
          end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
        end
        RECV: begin
          if (sample) begin
            cycle_cnt <= '0;
            shreg     <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt  <= '0;
              stop_bad <= 1'b0;
              state    <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (sample) begin
            cycle_cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              // Leaving at mid-stop lets a back-to-back start edge be caught.
              state        <= IDLE;
              bit_cnt      <= '0;
              stop_bad     <= 1'b0;
              uart_rx_data <= shreg;
              if (bad_frame) begin
                uart_rx_frame_err <= 1'b1;
                uart_rx_break     <= (shreg == '0);
              end else begin
                uart_rx_valid <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              stop_bad <= bad_frame;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised bench for uart_rx: a bit-level transmitter model
// drives the pin and a frame-level model predicts each result pulse.
module tb_uart_rx;

  localparam int BIT_CLKS = 435;
  localparam int LATENCY  = 4135;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       en = 1'b1;
  logic       busy, valid, ferr, brk;
  logic [7:0] data;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_t0  = 0;
  int busy_low = 0;
  bit track_busy = 1'b0;

  typedef struct {
    logic       v;
    logic       fe;
    logic       bk;
    logic [7:0] d;
    int         cyc;
  } ev_t;
  ev_t evq[$];

  uart_rx dut (
    .clk               (clk),
    .resetn            (resetn),
    .uart_rxd          (rxd),
    .uart_rx_en        (en),
    .uart_rx_busy      (busy),
    .uart_rx_valid     (valid),
    .uart_rx_data      (data),
    .uart_rx_frame_err (ferr),
    .uart_rx_break     (brk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid || ferr || brk)
      evq.push_back('{v: valid, fe: ferr, bk: brk, d: data, cyc: cyc});
    if (track_busy && cyc >= last_t0 + 3 && cyc <= last_t0 + LATENCY && !busy)
      busy_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, data LSB first, one stop bit; en drops for two bits at en_off.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int en_off);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    last_t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == en_off) en = 1'b0;
      if (i == en_off + 2) en = 1'b1;
      drive_bit(bits[i]);
    end
  endtask

  // Frame-level expectation: good stop -> valid, bad stop -> frame error,
  // bad stop with an all-zero payload -> break as well.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic stop,
                             input bit chk_lat);
    ev_t e;
    check({tag, "_pulses"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({tag, "_valid"}, e.v, stop);
      check({tag, "_ferr"},  e.fe, !stop);
      check({tag, "_break"}, e.bk, (!stop && d == 8'h00));
      check({tag, "_data"},  e.d, d);
      if (chk_lat) check({tag, "_latency"}, e.cyc - last_t0, LATENCY + 1);
    end
    evq.delete();
  endtask

  initial begin
    logic [7:0] b6;
    logic [7:0] rd;
    logic       rs;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_ferr", ferr, 0);
    check("rst_break", brk, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle(20);

    // 1: plain 0x55, latency and busy coverage
    track_busy = 1'b1;
    send_frame(8'h55, 1'b1, -10);
    track_busy = 1'b0;
    check_frame("t1", 8'h55, 1'b1, 1'b1);
    check("t1_busy_gaps", busy_low, 0);

    // 2: start-bit glitch
    idle(20);
    last_t0 = cyc;
    rxd = 1'b0;
    repeat (100) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (122) @(posedge clk);
    #1;
    check("t2_busy_fall", busy, 0);
    idle(300);
    check("t2_no_pulse", evq.size(), 0);
    check("t2_data_held", data, 8'h55);
    send_frame(8'h3C, 1'b1, -10);
    check_frame("t2", 8'h3C, 1'b1, 1'b1);

    // 3: stop bit driven low
    send_frame(8'hA3, 1'b0, -10);
    check_frame("t3", 8'hA3, 1'b0, 1'b1);
    idle(50);

    // 4: break, line low for 12 bit times
    last_t0 = cyc;
    rxd = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge clk);
    #1;
    check_frame("t4_brk", 8'h00, 1'b0, 1'b1);
    idle(50);
    check("t4_no_retrigger", evq.size(), 0);
    send_frame(8'h81, 1'b1, -10);
    check_frame("t4", 8'h81, 1'b1, 1'b1);

    // 5: back-to-back, en dropped mid second frame, then held low
    send_frame(8'h00, 1'b1, -10);
    check_frame("t5a", 8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 3);
    check_frame("t5b", 8'hFF, 1'b1, 1'b1);
    send_frame(8'h7E, 1'b1, -10);
    check_frame("t5c", 8'h7E, 1'b1, 1'b1);
    en = 1'b0;
    send_frame(8'h5A, 1'b1, -10);
    check("t5_en_off_pulses", evq.size(), 0);
    check("t5_en_off_data", data, 8'h7E);
    en = 1'b1;
    idle(20);

    // 6: asynchronous reset during data bit 4 of 0x96
    b6 = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b6[i]);
    rxd = b6[4];
    repeat (200) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("t6_busy_async", busy, 0);
    check("t6_valid_async", valid, 0);
    check("t6_data_async", data, 0);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1 resetn = 1'b1;
    idle(50);
    check("t6_no_pulse", evq.size(), 0);
    send_frame(b6, 1'b1, -10);
    check_frame("t6", b6, 1'b1, 1'b1);

    // Randomised payloads and stop bits
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      send_frame(rd, rs, -10);
      check_frame("rand", rd, rs, 1'b1);
      idle(10 + $urandom_range(0, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
